// File: rtl/secuenciador_bloques_pkg.sv
// Shared types and constants for the RTC bus-transaction sequencer.
// SECUENCIA_TIMER_EN adds the timer request type (indices 9..11).
package secuenciador_bloques_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } estado_t;

    localparam logic [3:0] IDX_INIT_FIRST   = 4'd0;
    localparam logic [3:0] IDX_FECHA_FIRST  = 4'd3;
    localparam logic [3:0] IDX_HORA_FIRST   = 4'd6;
    localparam logic [3:0] IDX_TIMER_FIRST  = 4'd9;
    localparam logic [3:0] IDX_LAST_LECTURA = 4'd8;
    localparam logic [3:0] IDX_IDLE         = 4'hF;

    // Request types double as bit positions; lower position = higher priority.
    localparam int REQ_INIT    = 0;
    localparam int REQ_HORA    = 1;
    localparam int REQ_FECHA   = 2;
    localparam int REQ_LECTURA = 3;
    localparam int REQ_TIMER   = 4;

`ifdef SECUENCIA_TIMER_EN
    localparam int NUM_REQ = 5;
`else
    localparam int NUM_REQ = 4;
`endif

    typedef struct packed {
        logic [3:0] first;
        logic [3:0] last;
        logic       wr;
    } rango_t;

    function automatic rango_t rango_de(input logic [NUM_REQ-1:0] g);
        rango_t r;
        r = '{first: IDX_IDLE, last: IDX_IDLE, wr: 1'b0};
        if (g[REQ_INIT])
            r = '{first: IDX_INIT_FIRST, last: IDX_INIT_FIRST + 4'd2, wr: 1'b1};
        else if (g[REQ_HORA])
            r = '{first: IDX_HORA_FIRST, last: IDX_HORA_FIRST + 4'd2, wr: 1'b1};
        else if (g[REQ_FECHA])
            r = '{first: IDX_FECHA_FIRST, last: IDX_FECHA_FIRST + 4'd2, wr: 1'b1};
        else if (g[REQ_LECTURA])
            r = '{first: IDX_FECHA_FIRST, last: IDX_LAST_LECTURA, wr: 1'b0};
`ifdef SECUENCIA_TIMER_EN
        else if (g[REQ_TIMER])
            r = '{first: IDX_TIMER_FIRST, last: IDX_TIMER_FIRST + 4'd2, wr: 1'b1};
`endif
        return r;
    endfunction

endpackage

// File: rtl/secuenciador_bloques_arbitro_prioridad.sv
// Pending-request latches with a fixed-priority one-hot grant.
// Width follows NUM_REQ, so the timer bit exists only with SECUENCIA_TIMER_EN.
module arbitro_prioridad
    import secuenciador_bloques_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] grant
);

    // A request landing on its own grant edge stays pending (set wins).
    always_ff @(posedge clk) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending & ~(take ? grant : '0)) | req;
    end

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/secuenciador_bloques.sv
// Arbitrates RTC sequence requests and steps Selec_Mux_DD through each range,
// handshaking every index via bus_start/bus_done with a timeout. Macro: SECUENCIA_TIMER_EN.
module secuenciador_bloques
    import secuenciador_bloques_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_init,
    input  logic       req_hora,
    input  logic       req_fecha,
    input  logic       req_lectura,
    input  logic       req_timer,
    input  logic       bus_done,
    output logic [3:0] Selec_Mux_DD,
    output logic       bus_start,
    output logic       bus_wr,
    output logic       busy,
    output logic       fin,
    output logic       error
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    estado_t            estado;
    logic [CW-1:0]      cnt;
    logic [3:0]         idx_last;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] grant;
    logic               take;
    rango_t             rango;

`ifdef SECUENCIA_TIMER_EN
    assign req = {req_timer, req_lectura, req_fecha, req_hora, req_init};
`else
    logic unused_timer;
    assign unused_timer = req_timer;
    assign req = {req_lectura, req_fecha, req_hora, req_init};
`endif

    // While busy is still high in IDLE the outputs are being cleaned up, so no grant yet.
    assign take  = (estado == ST_IDLE) && !busy && (|pending);
    assign rango = rango_de(grant);

    arbitro_prioridad u_arbitro (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .take    (take),
        .pending (pending),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= ST_IDLE;
            Selec_Mux_DD <= IDX_IDLE;
            idx_last     <= IDX_IDLE;
            bus_start    <= 1'b0;
            bus_wr       <= 1'b0;
            busy         <= 1'b0;
            fin          <= 1'b0;
            error        <= 1'b0;
            cnt          <= '0;
        end else begin
            bus_start <= 1'b0;
            fin       <= 1'b0;
            error     <= 1'b0;
            case (estado)
                ST_IDLE: begin
                    if (busy) begin
                        busy         <= 1'b0;
                        Selec_Mux_DD <= IDX_IDLE;
                        bus_wr       <= 1'b0;
                    end else if (take) begin
                        Selec_Mux_DD <= rango.first;
                        idx_last     <= rango.last;
                        bus_wr       <= rango.wr;
                        busy         <= 1'b1;
                        estado       <= ST_START;
                    end
                end
                ST_START: begin
                    bus_start <= 1'b1;
                    cnt       <= '0;
                    estado    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // bus_done on the expiry cycle still counts as success.
                    if (bus_done) begin
                        if (Selec_Mux_DD == idx_last) begin
                            estado <= ST_DONE;
                        end else begin
                            Selec_Mux_DD <= Selec_Mux_DD + 4'd1;
                            estado       <= ST_START;
                        end
                    end else if (cnt == CNT_LAST) begin
                        error  <= 1'b1;
                        estado <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    fin    <= 1'b1;
                    estado <= ST_IDLE;
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_bloques.sv
// Directed bench for secuenciador_bloques (TIMEOUT_CYC=4); timer case follows SECUENCIA_TIMER_EN.
module tb_secuenciador_bloques;

    logic       clk = 1'b0;
    logic       reset, req_init, req_hora, req_fecha, req_lectura, req_timer, bus_done;
    logic [3:0] Selec_Mux_DD;
    logic       bus_start, bus_wr, busy, fin, error;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_fin   = 0;
    int base_start, base_fin;

    always #5 clk = ~clk;

    secuenciador_bloques #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_init     (req_init),
        .req_hora     (req_hora),
        .req_fecha    (req_fecha),
        .req_lectura  (req_lectura),
        .req_timer    (req_timer),
        .bus_done     (bus_done),
        .Selec_Mux_DD (Selec_Mux_DD),
        .bus_start    (bus_start),
        .bus_wr       (bus_wr),
        .busy         (busy),
        .fin          (fin),
        .error        (error)
    );

    always @(negedge clk) begin
        if (bus_start) n_start++;
        if (fin) n_fin++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after the grant edge; bus_done returned 3 cycles after each bus_start.
    task automatic run_seq(input string tag, input logic [3:0] first, input logic [3:0] last,
                           input logic wr, input logic hora_pulse);
        chk({tag, " grant busy"}, busy, 1);
        chk({tag, " grant sel"}, Selec_Mux_DD, first);
        chk({tag, " grant wr"}, bus_wr, wr);
        for (int i = first; i <= last; i++) begin
            tick();
            chk({tag, " start"}, bus_start, 1);
            chk({tag, " sel"}, Selec_Mux_DD, i);
            chk({tag, " wr"}, bus_wr, wr);
            if (hora_pulse && i == first) req_hora = 1'b1;
            tick();
            req_hora = 1'b0;
            chk({tag, " start low"}, bus_start, 0);
            tick();
            bus_done = 1'b1;
            tick();
            bus_done = 1'b0;
            if (i != last) begin
                chk({tag, " next sel"}, Selec_Mux_DD, i + 1);
            end else begin
                chk({tag, " done fin"}, fin, 0);
                chk({tag, " done busy"}, busy, 1);
            end
        end
        tick();
        chk({tag, " fin"}, fin, 1);
        tick();
        chk({tag, " fin low"}, fin, 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle sel"}, Selec_Mux_DD, 4'hF);
        chk({tag, " idle wr"}, bus_wr, 0);
    endtask

    initial begin
        reset = 1'b1; req_init = 1'b0; req_hora = 1'b0; req_fecha = 1'b0;
        req_lectura = 1'b0; req_timer = 1'b0; bus_done = 1'b0;
        tick(); tick();
        chk("rst sel", Selec_Mux_DD, 4'hF);
        chk("rst outs", {bus_start, bus_wr, busy, fin, error}, 5'b0);
        reset = 1'b0;
        tick();

        // fecha write: 3,4,5
        base_start = n_start; base_fin = n_fin;
        req_fecha = 1'b1; tick(); req_fecha = 0;
        chk("fecha pend busy", busy, 0);
        tick();
        run_seq("fecha", 4'd3, 4'd5, 1'b1, 1'b0);
        chk("fecha n_start", n_start - base_start, 3);
        chk("fecha n_fin", n_fin - base_fin, 1);

        // init and lectura together: init first, then read 3..8
        tick();
        req_init = 1'b1; req_lectura = 1'b1; tick(); req_init = 1'b0; req_lectura = 1'b0;
        tick();
        run_seq("init", 4'd0, 4'd2, 1'b1, 1'b0);
        tick();
        run_seq("lectura", 4'd3, 4'd8, 1'b0, 1'b0);

        // two hora pulses during a fecha write: one hora sequence follows
        tick();
        base_start = n_start;
        req_fecha = 1'b1; tick(); req_fecha = 1'b0;
        req_hora = 1'b1; tick(); req_hora = 1'b0;
        run_seq("fecha2", 4'd3, 4'd5, 1'b1, 1'b1);
        tick();
        run_seq("hora", 4'd6, 4'd8, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        chk("hora once busy", busy, 0);
        chk("hora once n_start", n_start - base_start, 6);

        // timeout at index 1 of init
        base_fin = n_fin;
        req_init = 1'b1; tick(); req_init = 1'b0;
        tick();
        tick();
        chk("to start0", bus_start, 1);
        tick(); tick(); bus_done = 1'b1; tick(); bus_done = 1'b0;
        tick();
        chk("to start1 sel", Selec_Mux_DD, 1);
        chk("to start1", bus_start, 1);
        tick(); tick(); tick();
        chk("to no error early", error, 0);
        tick();
        chk("to error", error, 1);
        chk("to no fin", fin, 0);
        tick();
        chk("to error low", error, 0);
        chk("to sel", Selec_Mux_DD, 4'hF);
        chk("to busy", busy, 0);
        chk("to n_fin", n_fin - base_fin, 0);

        // reset during WAIT of index 7 with fecha pending
        tick();
        req_hora = 1'b1; tick(); req_hora = 1'b0;
        tick();
        tick(); tick(); tick(); bus_done = 1'b1; req_fecha = 1'b1; tick();
        bus_done = 1'b0; req_fecha = 1'b0;
        tick();
        chk("rw sel7", Selec_Mux_DD, 7);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rw sel", Selec_Mux_DD, 4'hF);
        chk("rw outs", {bus_start, bus_wr, busy, fin, error}, 5'b0);
        tick(); tick(); tick(); tick();
        chk("rw pending lost", busy, 0);

        // timer request
        base_start = n_start;
        req_timer = 1'b1; tick(); req_timer = 1'b0;
        tick();
`ifdef SECUENCIA_TIMER_EN
        run_seq("timer", 4'd9, 4'd11, 1'b1, 1'b0);
`else
        chk("timer busy", busy, 0);
        tick(); tick(); tick();
        chk("timer busy later", busy, 0);
        chk("timer n_start", n_start - base_start, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/secuenciador_bloques.md
# secuenciador_bloques

Sequencer and arbiter for the RTC bus-transaction path. It accepts one-cycle requests (init, hora write, fecha write, periodic read, optional timer write) from the control path and grants one at a time by fixed priority. For the granted request it steps `Selec_Mux_DD` through that request's register-index range, feeding the enable decoder and the data multiplexer. It handshakes each index with the bus-transaction unit through `bus_start` and `bus_done`, and guards each transfer with a timeout.

## Interface
- `TIMEOUT_CYC`, default 255: cycles allowed in WAIT for `bus_done` before abort; must be ≥2.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_init` in 1: pulse; request the init sequence.
- `req_hora` in 1: pulse; request the hora write.
- `req_fecha` in 1: pulse; request the fecha write.
- `req_lectura` in 1: pulse; request the periodic read.
- `req_timer` in 1: pulse; request the timer write. Used only with the macro.
- `bus_done` in 1: pulse from the bus-transaction unit; the current index transfer is complete.
- `Selec_Mux_DD` out 4: current register index. 4'hF when idle.
- `bus_start` out 1: one-cycle pulse that launches the transfer of `Selec_Mux_DD`.
- `bus_wr` out 1: 1 = write, 0 = read. Valid whenever busy.
- `busy` out 1: high from grant until return to IDLE.
- `fin` out 1: one-cycle pulse when a sequence completes normally.
- `error` out 1: one-cycle pulse on a timeout abort.

## Operation
- Pending latches: one bit per request type.
  - A request pulse sets its bit. Repeated pulses merge.
  - The bit is cleared at grant.
  - If a request arrives in the same cycle as its own grant, the set wins and the request is serviced again later.
- Priority, highest first: init > hora > fecha > lectura > timer.
- Index ranges and direction:
  - init: 0,1,2, write.
  - fecha: 3,4,5, write.
  - hora: 6,7,8, write.
  - lectura: 3..8, read.
  - timer: 9,10,11, write.
- FSM states: IDLE, START, WAIT, DONE.
  - IDLE: if any bit is pending, grant the highest-priority one. Load `Selec_Mux_DD` with the first index and `bus_wr` with the direction, set `busy`, go to START.
  - START: assert `bus_start`, clear the timeout counter, go to WAIT.
  - WAIT, on `bus_done`: if the index equals the last index, go to DONE. Otherwise increment `Selec_Mux_DD` and go to START.
  - WAIT, no `bus_done` after TIMEOUT_CYC cycles: pulse `error`, go to IDLE directly with no `fin`.
  - DONE: pulse `fin`, go to IDLE.
- On return to IDLE, `Selec_Mux_DD` goes to 4'hF, `busy` goes to 0, and `bus_wr` goes to 0.
- `bus_done` is ignored outside WAIT.
- Requests arriving while busy are latched and are not preempting.

## Timing
- Reset values: `Selec_Mux_DD`=4'hF; `bus_start`, `bus_wr`, `busy`, `fin`, `error`=0; all pending bits=0; FSM=IDLE; timeout counter=0.
- A reset asserted mid-sequence aborts immediately. No `fin` and no `error` are produced, and pending requests are lost.
- All outputs are registered.
- Request to bus activity:
  - A request is sampled at edge k.
  - Its pending bit is set after edge k.
  - Grant occurs at edge k+1.
  - `bus_start` is high between edges k+2 and k+3.
- `bus_done` sampled at edge m (not last index): new index after m, `bus_start` high during the following cycle.
- `bus_done` sampled at edge m (last index): `fin` is high during the cycle after m+1, and `busy` drops after m+2.
- Next grant: earliest at the edge after `busy` drops. Back-to-back sequences have one IDLE cycle between them.
- Timeout: counts cycles in WAIT. `bus_done` in the same cycle as expiry counts as success.
- Counter width: clog2(TIMEOUT_CYC+1).

## Configuration
- `SECUENCIA_TIMER_EN`:
  - Defined: the timer sequence (indices 9–11) and its pending bit exist.
  - Undefined: `req_timer` is ignored, no pending bit is synthesized, and indices 9–11 are never produced.

## Structure
- Shared package/include:
  - FSM state encoding.
  - Index constants: IDX_INIT_FIRST=0, IDX_FECHA_FIRST=3, IDX_HORA_FIRST=6, IDX_TIMER_FIRST=9, IDX_LAST_LECTURA=8, IDX_IDLE=4'hF.
  - Request-type encoding.
- Sub-module `arbitro_prioridad`: pending latches plus a fixed-priority grant with one-hot output.
- The FSM, index counter and timeout counter stay in the top level.

## Test plan
- `req_fecha` pulse, `bus_done` returned 3 cycles after each `bus_start`:
  - `Selec_Mux_DD` 3→4→5 with `bus_wr`=1.
  - Exactly 3 `bus_start` pulses, then 1 `fin`.
  - `Selec_Mux_DD` returns to 4'hF.
- `req_lectura` and `req_init` in the same cycle:
  - The init sequence (0,1,2, write) runs first.
  - After the IDLE gap, the read sequence runs: 3..8 with `bus_wr`=0.
- `req_hora` pulsed twice while a fecha write is busy: exactly one hora sequence (6,7,8) follows.
- TIMEOUT_CYC=4, `bus_done` withheld at index 1 of init:
  - `error` pulses 4 cycles after entering WAIT.
  - No `fin`; `Selec_Mux_DD`=4'hF and `busy`=0 on the next cycle.
- `reset` asserted during WAIT of index 7: all outputs return to reset values at the next edge, and pending requests are cleared.
- `req_timer` pulse:
  - With `SECUENCIA_TIMER_EN`: indices 9,10,11 are produced.
  - Without it: `busy` stays 0.
